// File: rtl/data_path.sv
// Multi-cycle ARM-subset core: register file, ALU/shifter, flags, IR, MAR/MDR,
// byte-addressed big-endian RAM and the FSM that sequences them.

module data_path_regs #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  ra_n,
    input  logic [3:0]  ra_m,
    input  logic [3:0]  ra_d,
    output logic [31:0] rn_val,
    output logic [31:0] rm_val,
    output logic [31:0] rd_val,
    output logic [31:0] pc_val,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [31:0] wdata,
    input  logic        pc_we,
    input  logic [31:0] pc_wdata
);
    logic [31:0] reg_to_mult [0:15];

    assign rn_val = reg_to_mult[ra_n];
    assign rm_val = reg_to_mult[ra_m];
    assign rd_val = reg_to_mult[ra_d];
    assign pc_val = reg_to_mult[15];

    // The general port is applied last so an Rd=15 write wins over the PC port.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 15; i++) reg_to_mult[i] <= '0;
            reg_to_mult[15] <= RESET_PC;
        end else begin
            if (pc_we) reg_to_mult[15] <= pc_wdata;
            if (we)    reg_to_mult[waddr] <= wdata;
        end
    end
endmodule

module data_path_ram #(
    parameter int MEM_BYTES = 512,
    parameter int AW        = 9
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    output logic [31:0]   rdata,
    input  logic          we_word,
    input  logic          we_byte,
    input  logic [31:0]   wdata
);
    logic [7:0]    memory [0:MEM_BYTES-1];
    logic [AW-1:0] a1, a2, a3;

    assign a1    = addr + AW'(1);
    assign a2    = addr + AW'(2);
    assign a3    = addr + AW'(3);
    assign rdata = {memory[addr], memory[a1], memory[a2], memory[a3]};

    always_ff @(posedge clk) begin
        if (we_word) begin
            memory[addr] <= wdata[31:24];
            memory[a1]   <= wdata[23:16];
            memory[a2]   <= wdata[15:8];
            memory[a3]   <= wdata[7:0];
        end else if (we_byte) begin
            memory[addr] <= wdata[7:0];
        end
    end
endmodule

module data_path #(
    parameter int          MEM_BYTES = 512,
    parameter logic [31:0] RESET_PC  = 32'd0
) (
    input  logic       main_clk,
    input  logic       reset,
    output logic [9:0] current_state
);
    localparam int AW = $clog2(MEM_BYTES);

    typedef enum logic [9:0] {
        S_RESET      = 10'd0,
        S_FETCH_ADDR = 10'd1,
        S_FETCH_READ = 10'd2,
        S_FETCH_IR   = 10'd3,
        S_DECODE     = 10'd4,
        S_DATA_PROC  = 10'd10,
        S_LS_ADDR    = 10'd20,
        S_LDR_READ   = 10'd21,
        S_LDR_WB     = 10'd22,
        S_STR_WRITE  = 10'd23,
        S_BRANCH     = 10'd30
    } state_t;

    state_t      state;
    logic [31:0] address, mdr, ir, alu_out;
    logic [3:0]  flags;

    logic [31:0] rn_val, rm_val, rd_val, pc_val, ram_rdata;
    logic        rf_we, pc_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata, pc_wdata;
    logic        we_word, we_byte;

    logic [3:0]  opcode;
    logic        is_test, arith, cond_ok, f_z, f_n, f_c, f_v;
    logic [4:0]  rot, sh_amt;
    logic [31:0] imm_rot, shifted, op2, ax, bx, ls_addr;
    logic        cin;
    logic [32:0] sum;
    logic [3:0]  new_flags;

    assign current_state = state;
    assign opcode  = ir[24:21];
    assign is_test = (opcode[3:2] == 2'b10);
    assign {f_z, f_n, f_c, f_v} = flags;

    data_path_regs #(.RESET_PC(RESET_PC)) register_file (
        .clk(main_clk), .reset(reset),
        .ra_n(ir[19:16]), .ra_m(ir[3:0]), .ra_d(ir[15:12]),
        .rn_val(rn_val), .rm_val(rm_val), .rd_val(rd_val), .pc_val(pc_val),
        .we(rf_we), .waddr(rf_waddr), .wdata(rf_wdata),
        .pc_we(pc_we), .pc_wdata(pc_wdata)
    );

    data_path_ram #(.MEM_BYTES(MEM_BYTES), .AW(AW)) ram (
        .clk(main_clk), .addr(address[AW-1:0]), .rdata(ram_rdata),
        .we_word(we_word), .we_byte(we_byte), .wdata(rd_val)
    );

    always_comb begin
        unique case (ir[31:28])
            4'h0:    cond_ok = f_z;
            4'h1:    cond_ok = !f_z;
            4'h2:    cond_ok = f_c;
            4'h3:    cond_ok = !f_c;
            4'h4:    cond_ok = f_n;
            4'h5:    cond_ok = !f_n;
            4'h6:    cond_ok = f_v;
            4'h7:    cond_ok = !f_v;
            4'h8:    cond_ok = f_c && !f_z;
            4'h9:    cond_ok = !f_c || f_z;
            4'hA:    cond_ok = (f_n == f_v);
            4'hB:    cond_ok = (f_n != f_v);
            4'hC:    cond_ok = !f_z && (f_n == f_v);
            4'hD:    cond_ok = f_z || (f_n != f_v);
            4'hE:    cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    // Operand 2: rotated immediate or immediate-shifted Rm (register shifts use amount 0).
    always_comb begin
        rot     = {ir[11:8], 1'b0};
        imm_rot = ({24'd0, ir[7:0]} >> rot) | ({24'd0, ir[7:0]} << (6'd32 - {1'b0, rot}));
        sh_amt  = ir[4] ? 5'd0 : ir[11:7];
        unique case (ir[6:5])
            2'b00:   shifted = rm_val << sh_amt;
            2'b01:   shifted = rm_val >> sh_amt;
            2'b10:   shifted = $signed(rm_val) >>> sh_amt;
            default: shifted = (rm_val >> sh_amt) | (rm_val << (6'd32 - {1'b0, sh_amt}));
        endcase
        op2 = ir[25] ? imm_rot : shifted;
    end

    // All arithmetic ops are x + y + cin; subtractions invert one operand.
    always_comb begin
        ax    = rn_val;
        bx    = op2;
        cin   = 1'b0;
        arith = 1'b1;
        unique case (opcode)
            4'h2, 4'hA: begin bx = ~op2; cin = 1'b1; end
            4'h3:       begin ax = op2; bx = ~rn_val; cin = 1'b1; end
            4'h5:       cin = f_c;
            4'h6:       begin bx = ~op2; cin = f_c; end
            4'h7:       begin ax = op2; bx = ~rn_val; cin = f_c; end
            4'h4, 4'hB: ;
            default:    arith = 1'b0;
        endcase
        sum = {1'b0, ax} + {1'b0, bx} + {32'd0, cin};
        unique case (opcode)
            4'h0, 4'h8: alu_out = rn_val & op2;
            4'h1, 4'h9: alu_out = rn_val ^ op2;
            4'hC:       alu_out = rn_val | op2;
            4'hD:       alu_out = op2;
            4'hE:       alu_out = rn_val & ~op2;
            4'hF:       alu_out = ~op2;
            default:    alu_out = sum[31:0];
        endcase
        new_flags = {alu_out == 32'd0, alu_out[31],
                     arith ? sum[32] : f_c,
                     arith ? ((ax[31] == bx[31]) && (sum[31] != ax[31])) : f_v};
    end

    assign ls_addr = ir[23] ? rn_val + {20'd0, ir[11:0]} : rn_val - {20'd0, ir[11:0]};

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = ir[15:12];
        rf_wdata = alu_out;
        pc_we    = 1'b0;
        pc_wdata = pc_val + 32'd4;
        unique case (state)
            S_FETCH_READ: pc_we = 1'b1;
            S_DATA_PROC:  rf_we = !is_test;
            S_LDR_WB:     begin rf_we = 1'b1; rf_wdata = mdr; end
            S_BRANCH: begin
                pc_we    = 1'b1;
                pc_wdata = pc_val + 32'd4 + {{6{ir[23]}}, ir[23:0], 2'b00};
                rf_we    = ir[24];
                rf_waddr = 4'd14;
                rf_wdata = pc_val;
            end
            default: ;
        endcase
    end

    assign we_word = (state == S_STR_WRITE) && !ir[22] && !reset;
    assign we_byte = (state == S_STR_WRITE) &&  ir[22] && !reset;

    always_ff @(posedge main_clk) begin
        if (reset) begin
            state   <= S_RESET;
            address <= '0;
            mdr     <= '0;
            ir      <= '0;
            flags   <= '0;
        end else begin
            unique case (state)
                S_RESET:      state <= S_FETCH_ADDR;
                S_FETCH_ADDR: begin address <= pc_val; state <= S_FETCH_READ; end
                S_FETCH_READ: begin mdr <= ram_rdata; state <= S_FETCH_IR; end
                S_FETCH_IR:   begin ir <= mdr; state <= S_DECODE; end
                S_DECODE: begin
                    if (!cond_ok)               state <= S_FETCH_ADDR;
                    else if (ir[27:26] == 2'b00) state <= S_DATA_PROC;
                    else if (ir[27:26] == 2'b01) state <= S_LS_ADDR;
                    else if (ir[27:25] == 3'b101) state <= S_BRANCH;
                    else                         state <= S_FETCH_ADDR;
                end
                S_DATA_PROC: begin
                    if (is_test || ir[20]) flags <= new_flags;
                    state <= S_FETCH_ADDR;
                end
                S_LS_ADDR: begin
                    address <= ls_addr;
                    state   <= ir[20] ? S_LDR_READ : S_STR_WRITE;
                end
                S_LDR_READ: begin
                    mdr   <= ir[22] ? {24'd0, ram_rdata[31:24]} : ram_rdata;
                    state <= S_LDR_WB;
                end
                default: state <= S_FETCH_ADDR;
            endcase
        end
    end
endmodule

// File: tb/tb_data_path.sv
// Directed program for data_path: runs a short preloaded program, checking
// state trace, registers, flags, RAM and per-instruction cycle counts.

module tb_data_path;
    logic       main_clk = 1'b0;
    logic       reset    = 1'b1;
    logic [9:0] current_state;

    int n_vec = 0;
    int n_bad = 0;

    data_path dut (
        .main_clk(main_clk),
        .reset(reset),
        .current_state(current_state)
    );

    always #5 main_clk = ~main_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge main_clk);
        #1;
    endtask

    task automatic load_word(input int a, input logic [31:0] w);
        dut.ram.memory[a]   = w[31:24];
        dut.ram.memory[a+1] = w[23:16];
        dut.ram.memory[a+2] = w[15:8];
        dut.ram.memory[a+3] = w[7:0];
    endtask

    // Runs from state 1 until state 1 comes round again, checking the cycle count.
    task automatic exec(input string tag, input int exp_cyc);
        int n = 0;
        do begin
            step();
            n++;
        end while (current_state != 10'd1 && n < 30);
        chk({tag, "_cycles"}, n, exp_cyc);
    endtask

    function automatic logic [31:0] r(input int i);
        return dut.register_file.reg_to_mult[i];
    endfunction

    initial begin
        for (int i = 0; i < 512; i++) dut.ram.memory[i] = 8'h00;
        load_word(0,   32'hE3A01005); // MOV  R1,#5
        load_word(4,   32'hE3510005); // CMP  R1,#5
        load_word(8,   32'hE2512006); // SUBS R2,R1,#6
        load_word(12,  32'hE5801040); // STR  R1,[R0,#64]
        load_word(16,  32'hE5903040); // LDR  R3,[R0,#64]
        load_word(20,  32'h0A000001); // BEQ  (not taken)
        load_word(24,  32'hEB000000); // BL
        load_word(32,  32'hE3510005); // CMP  R1,#5
        load_word(36,  32'h0A000001); // BEQ  (taken)
        load_word(48,  32'hE0914101); // ADDS R4,R1,R1,LSL #2
        load_word(52,  32'hE3A054FF); // MOV  R5,#0xFF000000
        load_word(56,  32'hE0956005); // ADDS R6,R5,R5
        load_word(60,  32'hE3A0F064); // MOV  PC,#100
        load_word(100, 32'hE5D08043); // LDRB R8,[R0,#67]
        load_word(104, 32'hE5C04044); // STRB R4,[R0,#68]
        load_word(108, 32'hE5119001); // LDR  R9,[R1,#-1]
        load_word(112, 32'hF3A0A001); // never-condition MOV R10,#1
        load_word(116, 32'hE5801050); // STR  R1,[R0,#80]

        step();
        step();
        chk("rst_state", {22'd0, current_state}, 32'd0);
        chk("rst_pc", r(15), 32'd0);
        chk("rst_flags", {28'd0, dut.flags}, 32'd0);
        reset = 1'b0;

        step(); chk("trace1", {22'd0, current_state}, 32'd1);
        step(); chk("trace2", {22'd0, current_state}, 32'd2);
        step(); chk("trace3", {22'd0, current_state}, 32'd3);
        chk("pc_after_fetch", r(15), 32'd4);
        step(); chk("trace4", {22'd0, current_state}, 32'd4);
        chk("ir_mov", dut.ir, 32'hE3A01005);
        step(); chk("trace10", {22'd0, current_state}, 32'd10);
        step(); chk("mov_back1", {22'd0, current_state}, 32'd1);
        chk("mov_r1", r(1), 32'd5);
        chk("mov_flags", {28'd0, dut.flags}, 32'h0);
        chk("mov_pc", r(15), 32'd4);

        exec("cmp", 5);
        chk("cmp_flags", {28'd0, dut.flags}, 32'hA);
        chk("cmp_r1", r(1), 32'd5);

        exec("subs", 5);
        chk("subs_r2", r(2), 32'hFFFFFFFF);
        chk("subs_flags", {28'd0, dut.flags}, 32'h4);

        exec("str", 6);
        chk("str_mem", {dut.ram.memory[64], dut.ram.memory[65], dut.ram.memory[66], dut.ram.memory[67]}, 32'h00000005);

        exec("ldr", 7);
        chk("ldr_r3", r(3), 32'd5);

        exec("beq_nt", 4);
        chk("beq_nt_pc", r(15), 32'd24);

        exec("bl", 5);
        chk("bl_lr", r(14), 32'd28);
        chk("bl_pc", r(15), 32'd32);

        exec("cmp2", 5);
        exec("beq_t", 5);
        chk("beq_t_pc", r(15), 32'd48);

        exec("adds_lsl", 5);
        chk("adds_lsl_r4", r(4), 32'h19);
        chk("adds_lsl_flags", {28'd0, dut.flags}, 32'h0);

        exec("mov_rot", 5);
        chk("mov_rot_r5", r(5), 32'hFF000000);

        exec("adds_c", 5);
        chk("adds_c_r6", r(6), 32'hFE000000);
        chk("adds_c_flags", {28'd0, dut.flags}, 32'h6);

        exec("mov_pc", 5);
        chk("mov_pc_val", r(15), 32'd100);

        exec("ldrb", 7);
        chk("ldrb_r8", r(8), 32'd5);

        exec("strb", 6);
        chk("strb_mem68", {24'd0, dut.ram.memory[68]}, 32'h19);
        chk("strb_mem69", {24'd0, dut.ram.memory[69]}, 32'h00);

        exec("ldr_neg", 7);
        chk("ldr_neg_r9", r(9), 32'hE3510005);

        exec("nv", 4);
        chk("nv_r10", r(10), 32'd0);
        chk("nv_pc", r(15), 32'd116);

        begin
            int n = 0;
            while (current_state != 10'd23 && n < 20) begin
                step();
                n++;
            end
            chk("reach_str_write", {22'd0, current_state}, 32'd23);
        end
        reset = 1'b1;
        step();
        chk("abort_state", {22'd0, current_state}, 32'd0);
        chk("abort_mem", {dut.ram.memory[80], dut.ram.memory[81], dut.ram.memory[82], dut.ram.memory[83]}, 32'h0);
        chk("abort_r1", r(1), 32'd0);
        chk("abort_pc", r(15), 32'd0);
        chk("abort_mar", dut.address, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
